hazard_scoreboard: RTL and testbench

- Hazard and halt controller for the no-forwarding 5-stage MIPS-lite pipeline.
- Sits beside the ID stage. It decodes the instruction in IF/ID and tracks destination registers of in-flight instructions in a 3-slot scoreboard (EX, MEM, WB).
- Drives hazardDetected and haltSignal into the program counter and the IF/ID register.
- A RAW hazard stalls fetch until the producer reaches a stage where the register file returns the new value.

---
 rtl/hazard_scoreboard_pkg.sv | 25 ++
 rtl/hazard_scoreboard_if.sv | 23 ++
 rtl/hazard_scoreboard_instr_reg_decode.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 76 +++++++
 tb/tb_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the ID-stage hazard/halt controller of the MIPS-lite pipeline.
// Opcode map, register specifier width and the scoreboard slot format.
package hazard_scoreboard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
        OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10, OP_HALT = 6'h11
    } opcode_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

    // r0 is hard-wired to zero, so it can never carry a RAW dependency.
    function automatic logic src_hit(sb_entry_t e, logic [REG_W-1:0] src, logic used);
        return used && e.valid && (e.dest == src) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// IF/ID-side signal bundle between the ID stage and the hazard scoreboard.
// master = ID stage / PC control, slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
);
    logic [INSTR_W-1:0] id_instr;
    logic               id_valid;
    logic               branch_taken;
    logic               hazard_detected;
    logic               halt_signal;
    logic [CNT_W-1:0]   stall_cycles;

    modport master (
        output id_instr, id_valid, branch_taken,
        input  hazard_detected, halt_signal, stall_cycles
    );

    modport slave (
        input  id_instr, id_valid, branch_taken,
        output hazard_detected, halt_signal, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard_instr_reg_decode.sv
// Combinational register-usage decode of one instruction: which specifiers
// are read, whether a register is written, and which one.
module instr_reg_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [31:0]      instr_i,
    output logic [REG_W-1:0] rs_o,
    output logic [REG_W-1:0] rt_o,
    output logic [REG_W-1:0] dest_o,
    output logic             uses_rs_o,
    output logic             uses_rt_o,
    output logic             writes_o,
    output logic             is_halt_o
);
    logic [5:0]       op;
    logic [REG_W-1:0] rd;
    logic             unused_low;

    assign op         = instr_i[31:26];
    assign rs_o       = instr_i[25:21];
    assign rt_o       = instr_i[20:16];
    assign rd         = instr_i[15:11];
    assign unused_low = ^instr_i[10:0];

    always_comb begin
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        writes_o  = 1'b0;
        is_halt_o = 1'b0;
        dest_o    = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
                writes_o  = 1'b1;
                dest_o    = rd;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI, OP_LDW: begin
                uses_rs_o = 1'b1;
                writes_o  = 1'b1;
                dest_o    = rt_o;
            end
            OP_STW, OP_BEQ: begin
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
            end
            OP_BZ, OP_JR: uses_rs_o = 1'b1;
            OP_HALT:      is_halt_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detector and sticky halt for the no-forwarding 5-stage pipeline.
// Tracks destinations of instructions in EX, MEM and WB and stalls ID on a match.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb_if
);
    // Slot order: [0]=EX, [1]=MEM, [2]=WB. With a write-then-read register
    // file the WB producer is already visible, so that slot is not compared.
    localparam logic [2:0] CMP_MASK = (WB_BYPASS != 0) ? 3'b011 : 3'b111;

    logic [REG_W-1:0] rs, rt, dest;
    logic             uses_rs, uses_rt, writes, is_halt;

    sb_entry_t [2:0]  slot_q;
    sb_entry_t        ex_d;
    logic [2:0]       slot_hit;
    logic             issue_ok, hazard;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    instr_reg_decode u_decode (
        .instr_i   (sb_if.id_instr[31:0]),
        .rs_o      (rs),
        .rt_o      (rt),
        .dest_o    (dest),
        .uses_rs_o (uses_rs),
        .uses_rt_o (uses_rt),
        .writes_o  (writes),
        .is_halt_o (is_halt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cmp
            assign slot_hit[gi] = src_hit(slot_q[gi], rs, uses_rs) |
                                  src_hit(slot_q[gi], rt, uses_rt);
        end
    endgenerate

    assign issue_ok = sb_if.id_valid & ~sb_if.branch_taken & ~halt_q;
    assign hazard   = issue_ok & (|(slot_hit & CMP_MASK));

    always_comb begin
        ex_d = '0;
        if (issue_ok && !hazard && writes && (dest != '0)) begin
            ex_d.valid = 1'b1;
            ex_d.dest  = dest;
        end
        halt_d = halt_q | (issue_ok & ~hazard & is_halt);
        cnt_d  = cnt_q;
        if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            halt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            slot_q <= {slot_q[1:0], ex_d};
            halt_q <= halt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sb_if.hazard_detected = hazard;
    assign sb_if.halt_signal     = halt_q;
    assign sb_if.stall_cycles    = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard; two instances share the
// stimulus: A = WB bypass with 32-bit counter, B = no bypass with 3-bit counter.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.INSTR_W(32), .CNT_W(32)) if_a ();
    hazard_scoreboard_if #(.INSTR_W(32), .CNT_W(3))  if_b ();

    hazard_scoreboard #(.INSTR_W(32), .WB_BYPASS(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .sb_if(if_a)
    );
    hazard_scoreboard #(.INSTR_W(32), .WB_BYPASS(0), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .sb_if(if_b)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n_hz_a, n_hz_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: for each register, the ID cycle at which its latest
    // producer was accepted. A reader in cycle n sees a stale value while
    // n - accept_cycle <= 2 (bypass) or <= 3 (no bypass).
    int    lw [2][32];
    bit    halted [2];
    longint cnt [2];
    int    cyc = 0;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) lw[k][r] = -100;
            halted[k] = 1'b0;
            cnt[k]    = 0;
        end
    endfunction

    function automatic void dec(input logic [31:0] ins, output bit urs, output bit urt,
                                output bit wr, output int dst, output bit hlt);
        int op;
        op  = int'(ins[31:26]);
        urs = 0; urt = 0; wr = 0; dst = 0; hlt = 0;
        if (op <= 11 && op % 2 == 0) begin
            urs = 1; urt = 1; wr = 1; dst = int'(ins[15:11]);
        end else if (op <= 12) begin
            urs = 1; wr = 1; dst = int'(ins[20:16]);
        end else if (op == 13 || op == 15) begin
            urs = 1; urt = 1;
        end else if (op == 14 || op == 16) begin
            urs = 1;
        end else if (op == 17) begin
            hlt = 1;
        end
    endfunction

    function automatic bit model_hz(input int k, input logic [31:0] ins, input bit v, input bit br);
        bit urs, urt, wr, hlt;
        int dst, rs, rt, win;
        dec(ins, urs, urt, wr, dst, hlt);
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        win = (k == 0) ? 2 : 3;
        return v && !br && !halted[k] &&
               ((urs && rs != 0 && cyc - lw[k][rs] <= win) ||
                (urt && rt != 0 && cyc - lw[k][rt] <= win));
    endfunction

    function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    task automatic drive(input logic [31:0] ins, input bit v, input bit br);
        if_a.id_instr = ins; if_a.id_valid = v; if_a.branch_taken = br;
        if_b.id_instr = ins; if_b.id_valid = v; if_b.branch_taken = br;
    endtask

    // One pipeline cycle: drive, compare at negedge, advance model at posedge.
    task automatic step(input logic [31:0] ins, input bit v, input bit br);
        bit hz [2];
        bit urs, urt, wr, hlt;
        int dst;
        longint cmax;
        drive(ins, v, br);
        @(negedge clk);
        for (int k = 0; k < 2; k++) hz[k] = model_hz(k, ins, v, br);
        chk("hz_a", 64'(if_a.hazard_detected), 64'(hz[0]));
        chk("hz_b", 64'(if_b.hazard_detected), 64'(hz[1]));
        chk("halt_a", 64'(if_a.halt_signal), 64'(halted[0]));
        chk("halt_b", 64'(if_b.halt_signal), 64'(halted[1]));
        chk("cnt_a", 64'(if_a.stall_cycles), 64'(cnt[0]));
        chk("cnt_b", 64'(if_b.stall_cycles), 64'(cnt[1]));
        if (if_a.hazard_detected === 1'b1) n_hz_a++;
        if (if_b.hazard_detected === 1'b1) n_hz_b++;
        @(posedge clk);
        dec(ins, urs, urt, wr, dst, hlt);
        for (int k = 0; k < 2; k++) begin
            cmax = (k == 0) ? 64'hFFFF_FFFF : 7;
            if (v && !br && !halted[k] && !hz[k]) begin
                if (wr && dst != 0) lw[k][dst] = cyc;
                if (hlt) halted[k] = 1'b1;
            end
            if (hz[k] && cnt[k] != cmax) cnt[k]++;
        end
        cyc++;
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_hz_a", 64'(if_a.hazard_detected), 64'd0);
        chk("rst_hz_b", 64'(if_b.hazard_detected), 64'd0);
        chk("rst_halt_a", 64'(if_a.halt_signal), 64'd0);
        chk("rst_cnt_a", 64'(if_a.stall_cycles), 64'd0);
        chk("rst_cnt_b", 64'(if_b.stall_cycles), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        repeat (4) step(32'd0, 1'b0, 1'b0);
    endtask

    task automatic raw_pair(input string tag);
        n_hz_a = 0; n_hz_b = 0;
        step(enc(0, 1, 2, 3), 1'b1, 1'b0);
        repeat (4) step(enc(2, 3, 4, 5), 1'b1, 1'b0);
        chk({tag, "_stalls_a"}, 64'(n_hz_a), 64'd2);
        chk({tag, "_stalls_b"}, 64'(n_hz_b), 64'd3);
    endtask

    initial begin
        logic [31:0] ins;
        bit v, br;
        int op;
        model_reset();
        drive(enc(0, 3, 3, 3), 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hz_a", 64'(if_a.hazard_detected), 64'd0);
        chk("reset_halt_a", 64'(if_a.halt_signal), 64'd0);
        chk("reset_cnt_a", 64'(if_a.stall_cycles), 64'd0);
        reset = 1'b0;

        // Back-to-back producer/consumer
        raw_pair("b2b");
        chk("b2b_cnt_a", 64'(if_a.stall_cycles), 64'd2);
        chk("b2b_cnt_b", 64'(if_b.stall_cycles), 64'd3);
        drain();

        // One independent instruction between producer and consumer
        n_hz_a = 0; n_hz_b = 0;
        step(enc(1, 0, 7, 0), 1'b1, 1'b0);
        step(enc(6, 1, 2, 8), 1'b1, 1'b0);
        repeat (3) step(enc(12, 7, 9, 0), 1'b1, 1'b0);
        chk("gap1_stalls_a", 64'(n_hz_a), 64'd1);
        chk("gap1_stalls_b", 64'(n_hz_b), 64'd2);
        drain();

        // Writes to r0 never create hazards
        n_hz_a = 0; n_hz_b = 0;
        step(enc(0, 1, 2, 0), 1'b1, 1'b0);
        step(enc(2, 0, 0, 4), 1'b1, 1'b0);
        chk("r0_stalls_a", 64'(n_hz_a), 64'd0);
        chk("r0_stalls_b", 64'(n_hz_b), 64'd0);
        drain();

        // Taken branch masks the hazard and squashes the ID instruction
        n_hz_a = 0; n_hz_b = 0;
        step(enc(4, 1, 2, 6), 1'b1, 1'b0);
        step(enc(15, 6, 6, 0), 1'b1, 1'b1);
        chk("br_mask_a", 64'(n_hz_a), 64'd0);
        chk("br_mask_b", 64'(n_hz_b), 64'd0);
        drain();
        n_hz_a = 0; n_hz_b = 0;
        step(enc(0, 1, 2, 10), 1'b1, 1'b1);
        step(enc(2, 10, 10, 11), 1'b1, 1'b0);
        chk("squash_a", 64'(n_hz_a), 64'd0);
        chk("squash_b", 64'(n_hz_b), 64'd0);
        drain();

        // Reset in the second cycle of a stall, then the same pair again
        do_reset();
        step(enc(0, 1, 2, 3), 1'b1, 1'b0);
        step(enc(2, 3, 4, 5), 1'b1, 1'b0);
        drive(enc(2, 3, 4, 5), 1'b1, 1'b0);
        #2;
        chk("midstall_hz_a", 64'(if_a.hazard_detected), 64'd1);
        do_reset();
        raw_pair("after_rst");
        drain();

        // HALT is sticky and blocks further issue
        n_hz_a = 0; n_hz_b = 0;
        step(enc(17, 0, 0, 0), 1'b1, 1'b0);
        repeat (4) step(enc(0, 3, 3, 3), 1'b1, 1'b0);
        chk("halt_held_a", 64'(if_a.halt_signal), 64'd1);
        chk("halt_held_b", 64'(if_b.halt_signal), 64'd1);
        chk("halt_nostall_a", 64'(n_hz_a), 64'd0);
        do_reset();

        // Randomized traffic with occasional asynchronous resets
        ins = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                if (!(model_hz(0, ins, 1'b1, 1'b0) && $urandom_range(0, 1) == 1)) begin
                    op = int'($urandom_range(0, 19));
                    if (op == 17 && $urandom_range(0, 63) != 0) op = 0;
                    ins = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)));
                end
                v  = ($urandom_range(0, 9) != 0);
                br = ($urandom_range(0, 9) == 0);
                step(ins, v, br);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
